// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED pattern controller: mode encodings, LED
// constants, the speed limit and the button-event priority resolver.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_CHASE = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_e;

    // Winning button event for the current cycle.
    typedef enum logic [1:0] {
        EV_NONE,
        EV_MODE,
        EV_UP,
        EV_DOWN
    } event_e;

    localparam logic [7:0] LED_RST   = 8'h01;
    localparam logic [7:0] BLINK_A   = 8'h55;
    localparam logic [7:0] BLINK_B   = 8'hAA;
    localparam logic [1:0] MAX_SPEED = 2'd3;

    // Simultaneous events: mode beats up, up beats down; losers are dropped.
    function automatic event_e pick_event(input logic ev_mode, input logic ev_up,
                                          input logic ev_down);
        if (ev_mode)      return EV_MODE;
        else if (ev_up)   return EV_UP;
        else if (ev_down) return EV_DOWN;
        return EV_NONE;
    endfunction

    // COUNT -> CHASE -> BLINK -> HOLD -> COUNT.
    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(2'(m + 2'd1));
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Board-side signal bundle of the LED pattern controller: three raw buttons
// in, LED bank and current mode out. The controller uses the slave view.
interface led_pattern_ctrl_if;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic [7:0] LED;
    logic [1:0] mode;

    modport master (output btn_mode, btn_up, btn_down, input LED, mode);
    modport slave  (input btn_mode, btn_up, btn_down, output LED, mode);
endinterface

// File: rtl/led_pattern_ctrl_btn_conditioner.sv
// btn_conditioner: 2-FF synchroniser, optional debounce and rising-edge
// detect for one raw push button. Debounce is built when the macro
// LED_PATTERN_DEBOUNCE_EN is defined; otherwise the level follows the
// synchroniser and DB_BITS only feeds the parameter check.
module btn_conditioner
    import led_ctrl_pkg::*;
#(
    parameter int DB_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic event_o
);

    // A counter narrower than two bits gives no usable stable time.
    if (DB_BITS < 2) begin : g_db_bits_check
        $fatal(1, "btn_conditioner: DB_BITS must be at least 2");
    end

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic prev_q;
    logic event_q;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef LED_PATTERN_DEBOUNCE_EN
    // Toggle after 2^DB_BITS-1 consecutive disagreeing cycles: the counter
    // reaches DB_LAST on the cycle before the final disagreeing one.
    localparam logic [DB_BITS-1:0] DB_LAST = DB_BITS'((64'd1 << DB_BITS) - 64'd2);

    logic [DB_BITS-1:0] db_cnt_q;
    logic               level_q;

    // Debounce: any agreeing cycle restarts the stable-time count.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
        end else if (sync2_q == level_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_cnt_q <= '0;
            level_q  <= ~level_q;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    // Registered one-cycle pulse on each rising edge of the conditioned level.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            event_q <= 1'b0;
        end else begin
            prev_q  <= level;
            event_q <= level & ~prev_q;
        end
    end

    assign event_o = event_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: conditions three buttons, resolves event priority and
// runs the COUNT/CHASE/BLINK/HOLD mode machine that drives an 8-LED bank.
// Button debounce is included when LED_PATTERN_DEBOUNCE_EN is defined.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 3000000,
    parameter int DB_BITS  = 16
) (
    input  logic               clk,
    input  logic               rst,
    led_pattern_ctrl_if.slave  bus
);

    // The fastest speed divides the step period by 8.
    if (TICK_DIV < 8) begin : g_tick_div_check
        $fatal(1, "led_pattern_ctrl: TICK_DIV must be at least 8");
    end

    localparam int TW = $clog2(TICK_DIV + 1);

    logic   ev_mode;
    logic   ev_up;
    logic   ev_down;
    event_e ev;

    btn_conditioner #(.DB_BITS(DB_BITS)) u_cond_mode (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (bus.btn_mode),
        .event_o (ev_mode)
    );

    btn_conditioner #(.DB_BITS(DB_BITS)) u_cond_up (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (bus.btn_up),
        .event_o (ev_up)
    );

    btn_conditioner #(.DB_BITS(DB_BITS)) u_cond_down (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (bus.btn_down),
        .event_o (ev_down)
    );

    assign ev = pick_event(ev_mode, ev_up, ev_down);

    mode_e         mode_q,        mode_d;
    logic [7:0]    count_q,       count_d;
    logic [1:0]    speed_q,       speed_d;
    logic [2:0]    chase_pos_q,   chase_pos_d;
    logic          chase_up_q,    chase_up_d;
    logic          blink_phase_q, blink_phase_d;
    logic [7:0]    led_q,         led_d;
    logic [TW-1:0] tick_cnt_q,    tick_cnt_d;
    logic [TW-1:0] period;
    logic          tick;

    // Step period shrinks by a power of two per speed level.
    assign period = TW'(TICK_DIV) >> speed_q;
    assign tick   = (tick_cnt_q == period - 1'b1);

    // Next-state logic: one winning event, otherwise a pattern tick.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        mode_d        = mode_q;
        count_d       = count_q;
        speed_d       = speed_q;
        chase_pos_d   = chase_pos_q;
        chase_up_d    = chase_up_q;
        blink_phase_d = blink_phase_q;
        led_d         = led_q;
        tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;

        case (ev)
            EV_MODE: begin
                mode_d = next_mode(mode_q);
                case (mode_d)
                    MODE_COUNT: led_d = count_q;
                    MODE_CHASE: begin
                        chase_pos_d = 3'd0;
                        chase_up_d  = 1'b1;
                        led_d       = LED_RST;
                    end
                    MODE_BLINK: begin
                        blink_phase_d = 1'b0;
                        led_d         = BLINK_A;
                    end
                    default: ;  // HOLD keeps the LEDs as they are
                endcase
            end
            EV_UP: begin
                if (mode_q == MODE_COUNT) begin
                    count_d = count_q + 8'd1;
                    led_d   = count_q + 8'd1;
                end else if (mode_q != MODE_HOLD && speed_q != MAX_SPEED) begin
                    speed_d = speed_q + 2'd1;
                end
            end
            EV_DOWN: begin
                if (mode_q == MODE_COUNT) begin
                    count_d = count_q - 8'd1;
                    led_d   = count_q - 8'd1;
                end else if (mode_q != MODE_HOLD && speed_q != 2'd0) begin
                    speed_d = speed_q - 2'd1;
                end
            end
            default: begin
                // A tick only acts in a cycle with no winning event.
                if (tick && mode_q == MODE_CHASE) begin
                    if (chase_up_q) begin
                        if (chase_pos_q == 3'd7) begin
                            chase_up_d  = 1'b0;
                            chase_pos_d = 3'd6;
                        end else begin
                            chase_pos_d = chase_pos_q + 3'd1;
                        end
                    end else begin
                        if (chase_pos_q == 3'd0) begin
                            chase_up_d  = 1'b1;
                            chase_pos_d = 3'd1;
                        end else begin
                            chase_pos_d = chase_pos_q - 3'd1;
                        end
                    end
                    led_d = LED_RST << chase_pos_d;
                end else if (tick && mode_q == MODE_BLINK) begin
                    blink_phase_d = ~blink_phase_q;
                    led_d         = blink_phase_q ? BLINK_A : BLINK_B;
                end
            end
        endcase

        // A new mode or speed starts a full fresh period.
        if (mode_d != mode_q || speed_d != speed_q) begin
            tick_cnt_d = '0;
        end
    end

    // Mode FSM and pattern state, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q        <= MODE_COUNT;
            count_q       <= LED_RST;
            speed_q       <= 2'd0;
            chase_pos_q   <= 3'd0;
            chase_up_q    <= 1'b1;
            blink_phase_q <= 1'b0;
            led_q         <= LED_RST;
            tick_cnt_q    <= '0;
        end else begin
            mode_q        <= mode_d;
            count_q       <= count_d;
            speed_q       <= speed_d;
            chase_pos_q   <= chase_pos_d;
            chase_up_q    <= chase_up_d;
            blink_phase_q <= blink_phase_d;
            led_q         <= led_d;
            tick_cnt_q    <= tick_cnt_d;
        end
    end

    assign bus.LED  = led_q;
    assign bus.mode = mode_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Testbench for led_pattern_ctrl: directed scenarios plus random button
// traffic, compared every cycle against a behavioural model that schedules
// button effects by latency arithmetic and derives ticks from elapsed time.
`timescale 1ns/1ps
module tb_led_pattern_ctrl;

    localparam int TICK_DIV = 8;
    localparam int DB_BITS  = 4;
`ifdef LED_PATTERN_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    localparam int STABLE   = (1 << DB_BITS) - 1;
    // Edges from the first edge that samples a raw rise to the LED update.
    localparam int LAT      = DEB ? 3 + STABLE : 3;
    localparam int MIN_HOLD = DEB ? STABLE + 2 : 2;
    localparam int MIN_GAP  = DEB ? STABLE + 3 : 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    led_pattern_ctrl_if bus ();

    led_pattern_ctrl #(.TICK_DIV(TICK_DIV), .DB_BITS(DB_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_mode, m_count, m_speed, m_chase, m_phase, m_led, m_restart;
    logic [2:0] pend [int];  // effect edge -> {down, up, mode}

    function automatic int chase_led(input int idx);
        return (idx <= 7) ? (1 << idx) : (1 << (14 - idx));
    endfunction

    task automatic model_edge();
        logic [2:0] ev;
        int period, delta, nspd;
        bit tick;
        if (rst) begin
            m_mode = 0; m_count = 1; m_speed = 0; m_chase = 0; m_phase = 0;
            m_led = 1; m_restart = cyc;
            pend.delete();
            return;
        end
        ev = 3'b000;
        if (pend.exists(cyc)) begin
            ev = pend[cyc];
            pend.delete(cyc);
        end
        period = TICK_DIV >> m_speed;
        tick = (cyc != m_restart) && ((cyc - m_restart) % period == 0);
        if (ev[0]) begin
            m_mode = (m_mode + 1) % 4;
            m_restart = cyc;
            case (m_mode)
                0: m_led = m_count;
                1: begin m_chase = 0; m_led = chase_led(0); end
                2: begin m_phase = 0; m_led = 'h55; end
                default: ;
            endcase
        end else if (ev[1] || ev[2]) begin
            delta = ev[1] ? 1 : -1;
            if (m_mode == 0) begin
                m_count = (m_count + delta + 256) % 256;
                m_led = m_count;
            end else if (m_mode != 3) begin
                nspd = m_speed + delta;
                if (nspd > 3) nspd = 3;
                if (nspd < 0) nspd = 0;
                if (nspd != m_speed) begin
                    m_speed = nspd;
                    m_restart = cyc;
                end
            end
        end else if (tick) begin
            if (m_mode == 1) begin
                m_chase = (m_chase + 1) % 14;
                m_led = chase_led(m_chase);
            end else if (m_mode == 2) begin
                m_phase ^= 1;
                m_led = m_phase ? 'hAA : 'h55;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("led", bus.LED, m_led);
        check("mode", bus.mode, m_mode);
    endtask

    task automatic set_btns(input logic [2:0] m);
        bus.btn_mode = m[0];
        bus.btn_up   = m[1];
        bus.btn_down = m[2];
    endtask

    task automatic schedule(input logic [2:0] mask, input int hold);
        int at;
        at = cyc + 1 + LAT;
        if (!DEB || hold >= STABLE) begin
            if (pend.exists(at)) pend[at] = pend[at] | mask;
            else pend[at] = mask;
        end
    endtask

    task automatic press(input logic [2:0] mask, input int hold, input int gap);
        set_btns(mask);
        schedule(mask, hold);
        repeat (hold) step();
        set_btns(3'b000);
        repeat (gap) step();
    endtask

    // Raise a button and count edges until LED or mode reacts, then release.
    task automatic press_watch(input logic [2:0] mask, output int n);
        logic [7:0] led0;
        logic [1:0] mode0;
        led0 = bus.LED;
        mode0 = bus.mode;
        set_btns(mask);
        schedule(mask, MIN_HOLD + 100);
        n = 0;
        while (bus.LED == led0 && bus.mode == mode0 && n < 100) begin
            step();
            n++;
        end
        repeat (MIN_HOLD) step();
        set_btns(3'b000);
        repeat (MIN_GAP) step();
    endtask

    // Align to one LED change, then measure cycles to the next.
    task automatic step_interval(output int dt);
        logic [7:0] prev;
        int n;
        prev = bus.LED;
        n = 0;
        while (bus.LED == prev && n < 64) begin step(); n++; end
        prev = bus.LED;
        dt = 0;
        while (bus.LED == prev && dt < 64) begin step(); dt++; end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int dt;
        logic [2:0] masks [7];
        masks = '{3'b001, 3'b010, 3'b100, 3'b110, 3'b011, 3'b101, 3'b111};
        set_btns(3'b000);

        // Reset state on the first cycle after release.
        do_reset(3);
        step();
        check("rst_led", bus.LED, 8'h01);
        check("rst_mode", bus.mode, 2'd0);

        // Glitch train: 5 high / 5 low for 100 cycles.
        for (int i = 0; i < 10; i++) press(3'b010, 5, 5);
        repeat (MIN_GAP) step();
        check("glitch", bus.LED, DEB ? 8'h01 : 8'h0B);

        // Counting up and wrap-around down.
        do_reset(2);
        for (int i = 0; i < 3; i++) press(3'b010, 30, 30);
        check("count_up3", bus.LED, 8'h04);
        for (int i = 0; i < 4; i++) press(3'b100, 30, 30);
        check("count_zero", bus.LED, 8'h00);
        press(3'b100, 30, 30);
        check("count_wrap", bus.LED, 8'hFF);

        // Raw-edge to LED latency.
        press_watch(3'b010, n);
        check("press_latency", n, LAT + 1);

        // Chase entry and speed control.
        do_reset(2);
        press_watch(3'b001, n);
        check("chase_mode", bus.mode, 2'd1);
        step_interval(dt);
        check("chase_div8", dt, 8);
        press(3'b010, MIN_HOLD, MIN_GAP);
        step_interval(dt);
        check("chase_div4", dt, 4);
        for (int i = 0; i < 3; i++) press(3'b010, MIN_HOLD, MIN_GAP);
        step_interval(dt);
        check("chase_div1", dt, 1);

        // Chase entry LED value captured on the reacting edge.
        do_reset(2);
        set_btns(3'b001);
        schedule(3'b001, MIN_HOLD + 100);
        n = 0;
        while (bus.mode == 2'd0 && n < 100) begin step(); n++; end
        check("chase_entry_led", bus.LED, 8'h01);
        repeat (MIN_HOLD) step();
        set_btns(3'b000);
        repeat (MIN_GAP) step();

        // Simultaneous mode + up in COUNT: mode wins, count untouched.
        do_reset(2);
        press(3'b011, MIN_HOLD, MIN_GAP);
        check("simul_mode", bus.mode, 2'd1);
        for (int i = 0; i < 3; i++) press(3'b001, MIN_HOLD, MIN_GAP);
        check("simul_back_mode", bus.mode, 2'd0);
        check("simul_count", bus.LED, 8'h01);

        // Reset during BLINK while showing AA.
        press(3'b001, MIN_HOLD, MIN_GAP);
        press(3'b001, MIN_HOLD, MIN_GAP);
        n = 0;
        while (bus.LED != 8'hAA && n < 64) begin step(); n++; end
        check("blink_aa", bus.LED, 8'hAA);
        rst = 1'b1;
        step();
        check("midrst_led", bus.LED, 8'h01);
        check("midrst_mode", bus.mode, 2'd0);
        rst = 1'b0;
        step();

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 14) == 0) begin
                do_reset(1);
                step();
            end
            press(masks[$urandom_range(0, 6)], MIN_HOLD + int'($urandom_range(0, 6)),
                  MIN_GAP + int'($urandom_range(0, 20)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Controller that sequences the board's 8-LED bank from three push buttons. It conditions each raw button (synchronise, debounce, rising-edge detect) and prioritises simultaneous presses. It then runs a mode state machine that drives the LEDs as an up/down counter, a bouncing chase, an alternating blink, or a frozen hold. It sits between the board button pins and the LED pins, and replaces per-program ad-hoc counter/blink logic.

## Interface
- TICK_DIV, 3000000: base pattern step period in clk cycles (300 ms at 10 MHz); must be ≥ 8.
- DB_BITS, 16: debounce counter width; stable time = 2^DB_BITS − 1 cycles.
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- btn_mode  in  1  raw asynchronous button: advance mode.
- btn_up  in  1  raw asynchronous button: increment count / speed up.
- btn_down  in  1  raw asynchronous button: decrement count / slow down.
- LED  out  8  LED drive, registered.
- mode  out  2  current mode, registered: 0 COUNT, 1 CHASE, 2 BLINK, 3 HOLD.

## Operation
- Reset values:
  - LED = 8'h01, mode = COUNT, count = 8'h01, speed = 0, tick counter = 0.
  - Chase position = bit0, chase direction = up, blink phase = 0.
  - All debounced levels = 0, all edge pulses = 0.
- Conditioning, per button:
  - 2-FF synchroniser.
  - The debounced level toggles after the synchronised input differs from it for 2^DB_BITS − 1 consecutive cycles. Any agreeing cycle clears the counter.
  - Rising edge of the debounced level gives a 1-cycle event. Falling edges give no event.
- Priority for events in the same cycle: mode > up > down. Only the winning event acts; the others are dropped, not queued.
- Mode FSM: the mode event advances COUNT → CHASE → BLINK → HOLD → COUNT.
- Mode entry:
  - COUNT: LED = retained count.
  - CHASE: LED = 8'h01, direction up.
  - BLINK: LED = 8'h55, phase 0.
  - HOLD: LED unchanged.
- COUNT:
  - up: count + 1, wraps 8'hFF → 8'h00.
  - down: count − 1, wraps 8'h00 → 8'hFF.
  - LED = count. Ticks are ignored.
- CHASE: each tick shifts the lit bit one position. It reverses at bit7 and bit0, giving a 14-tick period: 01, 02 … 80, 40 … 02, 01.
- BLINK: each tick toggles LED between 8'h55 and 8'hAA.
- CHASE/BLINK speed control:
  - up: speed + 1, saturates at 3.
  - down: speed − 1, saturates at 0.
- HOLD: up/down ignored, LED frozen.
- Count and speed are retained across mode changes; only reset clears them.

## Timing
- Tick period = TICK_DIV >> speed cycles. The tick counter counts 0 … period − 1 and pulses at the terminal value.
- The tick counter clears on any mode change or speed change; the first tick follows one full new period.
- An event and a tick in the same cycle: the event wins and the tick is discarded.
- Latency from a raw edge to the event pulse:
  - with debounce: 2 (sync) + 2^DB_BITS − 1 (debounce) + 1 (edge) cycles;
  - without debounce: 2 + 1 cycles.
- Latency from event pulse, or tick, to LED/mode updated: 1 cycle.
- Reset asserted mid-operation: all registers return to reset values on the next clk edge, including the debounce state.
- A button held through reset deassert produces one event once the debounced level rises.

## Configuration
- LED_PATTERN_DEBOUNCE_EN defined: the debounce counter is present, and DB_BITS applies.
- Undefined: the debounced level equals the synchroniser output, and DB_BITS is unused. This is for fast simulation and for boards with hardware debounce.

## Structure
- Shared package led_ctrl_pkg:
  - mode encodings MODE_COUNT/CHASE/BLINK/HOLD;
  - constants LED_RST = 8'h01, BLINK_A = 8'h55, BLINK_B = 8'hAA;
  - MAX_SPEED = 3.
- Sub-module btn_conditioner (synchroniser + debounce + rising-edge detect, parameter DB_BITS), instantiated three times.
- The FSM, tick divider and LED datapath stay in led_pattern_ctrl.

## Test plan
Use TICK_DIV = 8 and DB_BITS = 4 (debounce enabled) unless noted.
- Reset: hold rst 3 cycles → LED = 8'h01 and mode = 0 on the first cycle after release, with no events.
- Counting: 3 clean presses of btn_up (each held 30 cycles) → LED = 8'h04. From count 8'h00, one btn_down → 8'hFF.
- Glitch rejection: btn_up pulses of 5 cycles high / 5 low for 100 cycles → LED unchanged at 8'h01.
- Chase and speed:
  - btn_mode → mode = 1, LED = 8'h01.
  - LED then steps 02, 04, 08 every 8 cycles.
  - btn_up → steps every 4 cycles.
  - Three further btn_up presses → steps every 1 cycle (speed saturates at 3).
- Simultaneous presses: btn_mode and btn_up raised in the same cycle while in COUNT → mode = 1, count still 8'h01 (checked after returning to COUNT via three more btn_mode presses).
- Reset mid-pattern: rst during BLINK with LED = 8'hAA → next cycle LED = 8'h01 and mode = 0. Repeat with the macro undefined: a press takes effect 4 cycles after the raw edge.
